// File: rtl/wb_writeback_stage_pkg.sv
// Shared encodings for the MEM/WB writeback stage: load sizes, FSM states
// and the hard-wired zero register.
package wb_writeback_stage_pkg;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_MEM
  } wb_state_e;

endpackage

// File: rtl/wb_load_extend.sv
// Little-endian lane select of a load word followed by sign or zero extension.
module wb_load_extend
  import wb_writeback_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    unique case (byte_off)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    // Halfword lane comes from the upper address bit only.
    half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (size)
      LS_BYTE: data = {{(XLEN-8){~load_unsigned & byte_lane[7]}}, byte_lane};
      LS_HALF: data = {{(XLEN-16){~load_unsigned & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_writeback_stage.sv
// MEM/WB pipeline register and writeback controller: one register-file write
// per retired instruction, with a wait state for multi-cycle load data.
module wb_writeback_stage
  import wb_writeback_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic [1:0]       in_load_size,
  input  logic             in_load_unsigned,
  input  logic [1:0]       in_byte_off,
  input  logic [4:0]       in_dest,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             RegWrite,
  output logic [4:0]       WriteReg,
  output logic [XLEN-1:0]  WriteData,
  output logic             load_pending,
  output logic [4:0]       pending_reg,
  output logic             stray_rsp,
  output logic [CNT_W-1:0] retire_count
);

  wb_state_e       state_q;
  logic [4:0]      ld_dest_q;
  logic            ld_wr_q;
  logic [1:0]      ld_size_q;
  logic            ld_unsigned_q;
  logic [1:0]      ld_off_q;
  logic [XLEN-1:0] ext_data;

  wb_load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .size         (ld_size_q),
    .load_unsigned(ld_unsigned_q),
    .byte_off     (ld_off_q),
    .rdata        (mem_rdata),
    .data         (ext_data)
  );

  assign in_ready     = (state_q == IDLE);
  assign load_pending = (state_q == WAIT_MEM);
  assign pending_reg  = load_pending ? ld_dest_q : REG_ZERO;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      RegWrite      <= 1'b0;
      WriteReg      <= REG_ZERO;
      WriteData     <= '0;
      stray_rsp     <= 1'b0;
      retire_count  <= '0;
      ld_dest_q     <= REG_ZERO;
      ld_wr_q       <= 1'b0;
      ld_size_q     <= LS_WORD;
      ld_unsigned_q <= 1'b0;
      ld_off_q      <= 2'd0;
    end else begin
      RegWrite <= 1'b0;
      // Responses are only legal from the cycle after a load is accepted.
      if (mem_rvalid && (state_q != WAIT_MEM)) begin
        stray_rsp <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_mem_to_reg) begin
              ld_dest_q     <= in_dest;
              ld_wr_q       <= in_reg_write;
              ld_size_q     <= in_load_size;
              ld_unsigned_q <= in_load_unsigned;
              ld_off_q      <= in_byte_off;
              state_q       <= WAIT_MEM;
            end else begin
              RegWrite     <= in_reg_write && (in_dest != REG_ZERO);
              WriteReg     <= in_dest;
              WriteData    <= in_alu_result;
              retire_count <= retire_count + CNT_W'(1);
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            RegWrite     <= ld_wr_q && (ld_dest_q != REG_ZERO);
            WriteReg     <= ld_dest_q;
            WriteData    <= ext_data;
            retire_count <= retire_count + CNT_W'(1);
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_writeback_stage.sv
// Directed, table-driven bench for wb_writeback_stage with a narrow retire
// counter so wrap-around is reachable.
module tb_wb_writeback_stage;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_reg_write;
  logic          in_mem_to_reg;
  logic [1:0]    in_load_size;
  logic          in_load_unsigned;
  logic [1:0]    in_byte_off;
  logic [4:0]    in_dest;
  logic [31:0]   in_alu_result;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          RegWrite;
  logic [4:0]    WriteReg;
  logic [31:0]   WriteData;
  logic          load_pending;
  logic [4:0]    pending_reg;
  logic          stray_rsp;
  logic [CW-1:0] retire_count;

  wb_writeback_stage #(
    .XLEN (32),
    .CNT_W(CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_reg_write    (in_reg_write),
    .in_mem_to_reg   (in_mem_to_reg),
    .in_load_size    (in_load_size),
    .in_load_unsigned(in_load_unsigned),
    .in_byte_off     (in_byte_off),
    .in_dest         (in_dest),
    .in_alu_result   (in_alu_result),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .RegWrite        (RegWrite),
    .WriteReg        (WriteReg),
    .WriteData       (WriteData),
    .load_pending    (load_pending),
    .pending_reg     (pending_reg),
    .stray_rsp       (stray_rsp),
    .retire_count    (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          rw;
    logic          m2r;
    logic [1:0]    sz;
    logic          us;
    logic [1:0]    off;
    logic [4:0]    dest;
    logic [31:0]   alu;
    logic          rv;
    logic [31:0]   rd;
    logic          e_rw;
    logic [4:0]    e_wreg;
    logic [31:0]   e_wdata;
    logic          e_rdy;
    logic          e_pend;
    logic [4:0]    e_preg;
    logic [CW-1:0] e_cnt;
    logic          e_stray;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got 0x%08h, expected 0x%08h", idx, name, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input vec_t t);
    chk("RegWrite", idx, 32'(RegWrite), 32'(t.e_rw));
    chk("WriteReg", idx, 32'(WriteReg), 32'(t.e_wreg));
    chk("WriteData", idx, WriteData, t.e_wdata);
    chk("in_ready", idx, 32'(in_ready), 32'(t.e_rdy));
    chk("load_pending", idx, 32'(load_pending), 32'(t.e_pend));
    if (t.e_pend) chk("pending_reg", idx, 32'(pending_reg), 32'(t.e_preg));
    chk("retire_count", idx, 32'(retire_count), 32'(t.e_cnt));
    chk("stray_rsp", idx, 32'(stray_rsp), 32'(t.e_stray));
  endtask

  task automatic drive_idle();
    in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0; in_load_size = 2'd0;
    in_load_unsigned = 0; in_byte_off = 2'd0; in_dest = 5'd0; in_alu_result = 32'h0;
    mem_rvalid = 0; mem_rdata = 32'h0;
  endtask

  // Inputs change on the falling edge; outputs are checked one falling edge later.
  task automatic apply(input int idx, input vec_t t);
    in_valid = t.v; in_reg_write = t.rw; in_mem_to_reg = t.m2r; in_load_size = t.sz;
    in_load_unsigned = t.us; in_byte_off = t.off; in_dest = t.dest; in_alu_result = t.alu;
    mem_rvalid = t.rv; mem_rdata = t.rd;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    check_outs(idx, t);
  endtask

  task automatic do_reset(input int idx);
    vec_t t;
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = '{0, 0, 0, 2'd0, 0, 2'd0, 5'd0, 32'h0, 0, 32'h0,
          0, 5'd0, 32'h0, 1, 0, 5'd0, CW'(0), 0};
    n_vec++;
    check_outs(idx, t);
  endtask

  initial begin
    vec_t t;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    do_reset(1000);

    // v rw m2r sz us off dest alu rv rd | rw wreg wdata rdy pend preg cnt stray
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd5,32'hDEADBEEF,0,32'h0,  1,5'd5,32'hDEADBEEF,1,0,5'd0,CW'(1),0});
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd1,32'h11,0,32'h0,        1,5'd1,32'h11,1,0,5'd0,CW'(2),0});
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd2,32'h22,0,32'h0,        1,5'd2,32'h22,1,0,5'd0,CW'(3),0});
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd3,32'h33,0,32'h0,        1,5'd3,32'h33,1,0,5'd0,CW'(4),0});
    // Signed byte load, off 2; MEM holds an ALU op that must not be taken while waiting.
    vecs.push_back('{1,1,1,2'd0,0,2'd2,5'd7,32'hAAAA,0,32'h0,      0,5'd3,32'h33,0,1,5'd7,CW'(4),0});
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd9,32'h99,0,32'h0,        0,5'd3,32'h33,0,1,5'd7,CW'(4),0});
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd9,32'h99,0,32'h0,        0,5'd3,32'h33,0,1,5'd7,CW'(4),0});
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd9,32'h99,1,32'h12F45678, 1,5'd7,32'hFFFFFFF4,1,0,5'd0,CW'(5),0});
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd9,32'h99,0,32'h0,        1,5'd9,32'h99,1,0,5'd0,CW'(6),0});
    // Unsigned half at off 2.
    vecs.push_back('{1,1,1,2'd1,1,2'd2,5'd8,32'h0,0,32'h0,         0,5'd9,32'h99,0,1,5'd8,CW'(6),0});
    vecs.push_back('{0,0,0,2'd0,0,2'd0,5'd0,32'h0,1,32'h12F45678,  1,5'd8,32'h000012F4,1,0,5'd0,CW'(7),0});
    // Writes to r0 retire without RegWrite.
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd0,32'h5555,0,32'h0,      0,5'd0,32'h5555,1,0,5'd0,CW'(8),0});
    vecs.push_back('{1,1,1,2'd0,0,2'd0,5'd0,32'h0,0,32'h0,         0,5'd0,32'h5555,0,1,5'd0,CW'(8),0});
    vecs.push_back('{0,0,0,2'd0,0,2'd0,5'd0,32'h0,1,32'h000000FF,  0,5'd0,32'hFFFFFFFF,1,0,5'd0,CW'(9),0});
    // Load with reg_write=0 still waits and retires.
    vecs.push_back('{1,0,1,2'd2,0,2'd3,5'd4,32'h0,0,32'h0,         0,5'd0,32'hFFFFFFFF,0,1,5'd4,CW'(9),0});
    vecs.push_back('{0,0,0,2'd0,0,2'd0,5'd0,32'h0,1,32'hCAFEF00D,  0,5'd4,32'hCAFEF00D,1,0,5'd0,CW'(10),0});
    // Response in IDLE is dropped and flagged.
    vecs.push_back('{0,0,0,2'd0,0,2'd0,5'd0,32'h0,1,32'h77777777,  0,5'd4,32'hCAFEF00D,1,0,5'd0,CW'(10),1});
    // Response in the accept cycle is ignored; the next one completes the load.
    vecs.push_back('{1,1,1,2'd2,0,2'd0,5'd6,32'h0,1,32'hBAD0BAD0,  0,5'd4,32'hCAFEF00D,0,1,5'd6,CW'(10),1});
    vecs.push_back('{0,0,0,2'd0,0,2'd0,5'd0,32'h0,1,32'h01020304,  1,5'd6,32'h01020304,1,0,5'd0,CW'(11),1});
    // Signed half, off 1 selects the low lane.
    vecs.push_back('{1,1,1,2'd1,0,2'd1,5'd10,32'h0,0,32'h0,        0,5'd6,32'h01020304,0,1,5'd10,CW'(11),1});
    vecs.push_back('{0,0,0,2'd0,0,2'd0,5'd0,32'h0,1,32'h00008001,  1,5'd10,32'hFFFF8001,1,0,5'd0,CW'(12),1});
    // Unsigned byte, off 3.
    vecs.push_back('{1,1,1,2'd0,1,2'd3,5'd11,32'h0,0,32'h0,        0,5'd10,32'hFFFF8001,0,1,5'd11,CW'(12),1});
    vecs.push_back('{0,0,0,2'd0,0,2'd0,5'd0,32'h0,1,32'hAB000000,  1,5'd11,32'h000000AB,1,0,5'd0,CW'(13),1});
    // Counter wraps from all-ones to zero.
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd1,32'h100,0,32'h0,       1,5'd1,32'h100,1,0,5'd0,CW'(14),1});
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd1,32'h101,0,32'h0,       1,5'd1,32'h101,1,0,5'd0,CW'(15),1});
    vecs.push_back('{1,1,0,2'd0,0,2'd0,5'd1,32'h102,0,32'h0,       1,5'd1,32'h102,1,0,5'd0,CW'(0),1});

    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset clears the sticky flag; a normal ALU op then writes.
    do_reset(1001);
    t = '{1,1,0,2'd0,0,2'd0,5'd2,32'h2222,0,32'h0, 1,5'd2,32'h2222,1,0,5'd0,CW'(1),0};
    apply(1002, t);

    // Reset while a load is pending discards it; the late response is a stray.
    t = '{1,1,1,2'd2,0,2'd0,5'd12,32'h0,0,32'h0, 0,5'd2,32'h2222,0,1,5'd12,CW'(1),0};
    apply(1003, t);
    do_reset(1004);
    t = '{0,0,0,2'd0,0,2'd0,5'd0,32'h0,1,32'h12345678, 0,5'd0,32'h0,1,0,5'd0,CW'(0),1};
    apply(1005, t);
    t = '{0,0,0,2'd0,0,2'd0,5'd0,32'h0,0,32'h0, 0,5'd0,32'h0,1,0,5'd0,CW'(0),1};
    apply(1006, t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
